// File: rtl/cam_nibble_packer.sv
// cam_nibble_packer
// Reads a captured frame out of the camera capture RAM one nibble at a time.
// It packs NIBBLES nibbles per word and hands each word to the Wishbone slave
// over a valid/ack handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; outputs quiet
// WAIT_RDY | readout requested, waiting for the synchronised ready level
// STROBE   | rd high for one cycle, add_rd held
// SETTLE   | rd low; RAM data captured into its word slot, add_rd advanced
// OUT      | packed word presented, waiting for word_ack
// DONE     | one-cycle done pulse after the last word is accepted
module cam_nibble_packer #(
    parameter int ADDR_W  = 4,
    parameter int NIBBLES = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   ready,
    output logic                   rd,
    output logic [ADDR_W-1:0]      add_rd,
    input  logic [3:0]             dataOut,
    output logic [4*NIBBLES-1:0]   word_data,
    output logic                   word_valid,
    input  logic                   word_ack,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int SLOT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NIBBLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        STROBE,
        SETTLE,
        OUT,
        DONE
    } state_t;

    state_t state, state_next;

    logic ready_meta;
    logic ready_s;
    logic ready_s_d;
    logic ready_rise;
    logic [SLOT_W-1:0] slot;

    // The low address bits select the nibble slot, so no separate nibble counter is kept.
    assign slot       = add_rd[SLOT_W-1:0];
    assign ready_rise = ready_s & ~ready_s_d;

    // Two-flop synchroniser for the asynchronous ready flag, plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_meta <= 1'b0;
            ready_s    <= 1'b0;
            ready_s_d  <= 1'b0;
        end else begin
            ready_meta <= ready;
            ready_s    <= ready_meta;
            ready_s_d  <= ready_s;
        end
    end

    // Next-state decode; abort overrides every transition.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = WAIT_RDY;
            WAIT_RDY: if (ready_s) state_next = STROBE;
            STROBE:   state_next = SETTLE;
            SETTLE:   state_next = (slot == LAST_SLOT) ? OUT : STROBE;
            OUT:      if (word_ack) state_next = (add_rd == '0) ? DONE : STROBE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (abort) state_next = IDLE;
    end

    // State register; rd is registered from the next state so it is high exactly while in STROBE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rd    <= 1'b0;
        end else begin
            state <= state_next;
            rd    <= (state_next == STROBE);
        end
    end

    // Read address and word assembly; add_rd only moves at the end of SETTLE, keeping it stable around rd.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            add_rd    <= '0;
            word_data <= '0;
        end else if (abort) begin
            add_rd <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) add_rd <= '0;
                end
                SETTLE: begin
                    add_rd <= add_rd + ADDR_W'(1);
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (slot == SLOT_W'(k)) word_data[4*k +: 4] <= dataOut;
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky overrun: a fresh frame landed while the previous one was still being read out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (state == IDLE && start && !abort) begin
            overrun <= 1'b0;
        end else if (ready_rise && state != IDLE && state != WAIT_RDY) begin
            overrun <= 1'b1;
        end
    end

    assign word_valid = (state == OUT);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_cam_nibble_packer.sv
// Directed bench for cam_nibble_packer with a RAM model, a word scoreboard
// and a negedge monitor for rd addresses, word hold and done pulses.
module tb_cam_nibble_packer;

    localparam int ADDR_W  = 4;
    localparam int NIBBLES = 8;
    localparam int DEPTH   = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ready = 1'b0;
    logic        word_ack = 1'b0;
    logic        rd;
    logic [3:0]  add_rd;
    logic [3:0]  dataOut = 4'h0;
    logic [31:0] word_data;
    logic        word_valid;
    logic        busy;
    logic        done;
    logic        overrun;

    logic [3:0]  mem [DEPTH];
    logic [31:0] sb [$];
    logic [3:0]  rd_log [$];

    int n_checks = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int cyc;

    logic        prev_valid = 1'b0;
    logic [31:0] prev_data = 32'h0;
    logic        prev_rd = 1'b0;
    logic [3:0]  prev_add = 4'h0;

    always #5 clk = ~clk;

    cam_nibble_packer #(.ADDR_W(ADDR_W), .NIBBLES(NIBBLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .ready      (ready),
        .rd         (rd),
        .add_rd     (add_rd),
        .dataOut    (dataOut),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ack   (word_ack),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    // Capture RAM read port: data appears after the clock edge that samples rd.
    always @(posedge clk) begin
        if (rd) dataOut <= mem[add_rd];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pack(input int base);
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < NIBBLES; k++) w[4*k +: 4] = mem[base + k];
        return w;
    endfunction

    // Monitor: log rd addresses, count done pulses, check word hold and score accepted words.
    always @(negedge clk) begin
        if (rd) rd_log.push_back(add_rd);
        if (done) done_cnt++;
        if (prev_rd && busy) check("addr_after_rd", 32'(add_rd), 32'(prev_add));
        if (word_valid) check("no_rd_in_out", 32'(rd), 32'h0);
        if (word_valid && prev_valid) check("data_hold", word_data, prev_data);
        if (word_valid && word_ack) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'h1);
            if (sb.size() != 0) check("word", word_data, sb.pop_front());
        end
        prev_valid = word_valid;
        prev_data  = word_data;
        prev_rd    = rd;
        prev_add   = add_rd;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            tick();
            cycles++;
        end
        check("done_seen", 32'(done), 32'h1);
    endtask

    task automatic push_frame();
        sb.push_back(pack(0));
        sb.push_back(pack(8));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 4'(i);

        // Reset held with inputs toggling
        reset = 1'b0; start = 1'b1; ready = 1'b1; word_ack = 1'b1;
        repeat (3) begin
            tick();
            start = ~start;
            abort = ~abort;
        end
        check("rst_rd", 32'(rd), 32'h0);
        check("rst_add_rd", 32'(add_rd), 32'h0);
        check("rst_word_data", word_data, 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        start = 1'b0; abort = 1'b0;
        reset = 1'b1;
        repeat (5) tick();
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_no_rd", 32'(rd_log.size()), 32'h0);
        check("idle_overrun", 32'(overrun), 32'h0);

        // Full frame, ack tied high, ready already high
        rd_log.delete(); done_cnt = 0;
        push_frame();
        pulse_start();
        run_to_done(200, cyc);
        check("frame_latency", 32'(cyc), 32'd35);
        check("busy_with_done", 32'(busy), 32'h1);
        check("rd_count", 32'(rd_log.size()), 32'd16);
        for (int i = 0; i < rd_log.size(); i++) check("rd_addr", 32'(rd_log[i]), 32'(i));
        tick();
        check("done_one_cycle", 32'(done), 32'h0);
        check("busy_fall", 32'(busy), 32'h0);
        check("done_count", 32'(done_cnt), 32'h1);
        check("sb_empty_a", 32'(sb.size()), 32'h0);

        // First word held 5 cycles without ack; start while busy is ignored
        word_ack = 1'b0;
        rd_log.delete(); done_cnt = 0;
        push_frame();
        pulse_start();
        cyc = 0;
        while (!word_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("valid_seen", 32'(word_valid), 32'h1);
        check("first_word_latency", 32'(cyc), 32'd17);
        check("rd_before_out", 32'(rd_log.size()), 32'd8);
        pulse_start();
        repeat (4) tick();
        check("valid_held", 32'(word_valid), 32'h1);
        check("no_rd_while_held", 32'(rd_log.size()), 32'd8);
        word_ack = 1'b1;
        run_to_done(200, cyc);
        tick();
        check("rd_count_b", 32'(rd_log.size()), 32'd16);
        check("done_count_b", 32'(done_cnt), 32'h1);
        check("sb_empty_b", 32'(sb.size()), 32'h0);
        check("idle_after_b", 32'(busy), 32'h0);

        // Start with ready low; rd appears 3 cycles after ready rises
        ready = 1'b0;
        repeat (4) tick();
        rd_log.delete(); done_cnt = 0;
        push_frame();
        pulse_start();
        repeat (9) tick();
        check("wait_busy", 32'(busy), 32'h1);
        check("wait_no_rd", 32'(rd_log.size()), 32'h0);
        ready = 1'b1;
        tick();
        check("rdy_lat1", 32'(rd), 32'h0);
        tick();
        check("rdy_lat2", 32'(rd), 32'h0);
        tick();
        check("rdy_lat3", 32'(rd), 32'h1);
        check("rdy_lat3_addr", 32'(add_rd), 32'h0);
        run_to_done(200, cyc);
        tick();
        check("no_overrun_c", 32'(overrun), 32'h0);
        check("sb_empty_c", 32'(sb.size()), 32'h0);

        // Random frame contents, ready re-rises mid-readout
        for (int i = 0; i < DEPTH; i++) mem[i] = 4'($urandom_range(0, 15));
        done_cnt = 0;
        push_frame();
        pulse_start();
        repeat (6) tick();
        ready = 1'b0;
        repeat (3) tick();
        ready = 1'b1;
        repeat (3) tick();
        check("overrun_set", 32'(overrun), 32'h1);
        run_to_done(200, cyc);
        tick();
        check("overrun_sticky", 32'(overrun), 32'h1);
        check("sb_empty_d", 32'(sb.size()), 32'h0);
        mem[3] = ~mem[3];
        push_frame();
        pulse_start();
        check("overrun_cleared", 32'(overrun), 32'h0);
        run_to_done(200, cyc);
        tick();
        check("sb_empty_d2", 32'(sb.size()), 32'h0);

        // Abort during the 5th nibble, with overrun set beforehand
        rd_log.delete(); done_cnt = 0;
        pulse_start();
        cyc = 0;
        while (!rd && cyc < 20) begin
            tick();
            cyc++;
        end
        ready = 1'b0;
        repeat (3) tick();
        ready = 1'b1;
        repeat (3) tick();
        check("overrun_set_e", 32'(overrun), 32'h1);
        cyc = 0;
        while (!(rd && add_rd == 4'd4) && cyc < 20) begin
            tick();
            cyc++;
        end
        check("reached_nibble5", 32'(add_rd), 32'h4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_rd", 32'(rd), 32'h0);
        check("abort_add_rd", 32'(add_rd), 32'h0);
        check("abort_valid", 32'(word_valid), 32'h0);
        check("abort_overrun_held", 32'(overrun), 32'h1);
        repeat (20) tick();
        check("abort_no_done", 32'(done_cnt), 32'h0);
        check("abort_rd_count", 32'(rd_log.size()), 32'd5);
        check("abort_still_idle", 32'(busy), 32'h0);

        // Abort and start together in IDLE: abort wins
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_start_idle", 32'(busy), 32'h0);
        tick();
        check("abort_start_idle2", 32'(busy), 32'h0);
        check("abort_start_keeps_ovr", 32'(overrun), 32'h1);

        // Next start reads from address 0 again
        rd_log.delete(); done_cnt = 0;
        push_frame();
        pulse_start();
        check("restart_ovr_clear", 32'(overrun), 32'h0);
        run_to_done(200, cyc);
        tick();
        check("restart_rd_count", 32'(rd_log.size()), 32'd16);
        if (rd_log.size() != 0) check("restart_first_addr", 32'(rd_log[0]), 32'h0);
        check("restart_done_count", 32'(done_cnt), 32'h1);
        check("sb_empty_e", 32'(sb.size()), 32'h0);

        // Reset mid-readout
        done_cnt = 0;
        pulse_start();
        repeat (10) tick();
        reset = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_rd", 32'(rd), 32'h0);
        check("mid_rst_add_rd", 32'(add_rd), 32'h0);
        check("mid_rst_word_data", word_data, 32'h0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (40) tick();
        check("mid_rst_no_done", 32'(done_cnt), 32'h0);
        check("mid_rst_idle", 32'(busy), 32'h0);
        check("sb_empty_f", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
